// File: rtl/shift_pipeline.sv
// Two-stage valid/ready barrel shifter: S1 holds the operands, S2 holds the result.
// Optional zero flag on the result, enabled by defining SHIFT_PIPELINE_ZERO_FLAG_EN.
module shift_pipeline #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [N-1:0]         i_data,
  input  logic [$clog2(N)-1:0] i_shamt,
  input  logic [1:0]           i_op,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [N-1:0]         o_data,
`ifdef SHIFT_PIPELINE_ZERO_FLAG_EN
  output logic                 o_zero,
`endif
  output logic                 o_err
);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ILL = 2'b11} op_e;

  logic          r_s1_vld;
  logic [N-1:0]  r_s1_data;
  logic [SW-1:0] r_s1_shamt;
  logic [1:0]    r_s1_op;
  logic          r_s2_vld;
  logic [N-1:0]  r_s2_data;
  logic          r_s2_err;

  logic          w_s2_load;
  logic          w_s1_load;
  logic [N-1:0]  w_result;
  logic          w_err;

  // S2 frees up when empty or draining; S1 frees up when empty or moving into S2.
  assign w_s2_load = !r_s2_vld || o_ready;
  assign w_s1_load = !r_s1_vld || w_s2_load;
  assign i_ready   = !rst && w_s1_load;

  always_comb begin
    w_result = r_s1_data;
    w_err    = 1'b0;
    case (op_e'(r_s1_op))
      OP_SLL:  w_result = r_s1_data << r_s1_shamt;
      OP_SRL:  w_result = r_s1_data >> r_s1_shamt;
      OP_SRA:  w_result = $signed(r_s1_data) >>> r_s1_shamt;
      default: w_err    = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_data  <= '0;
      r_s1_shamt <= '0;
      r_s1_op    <= '0;
    end else if (w_s1_load) begin
      r_s1_vld <= i_valid;
      if (i_valid) begin
        r_s1_data  <= i_data;
        r_s1_shamt <= i_shamt;
        r_s1_op    <= i_op;
      end
    end
  end

  // Payload only moves with a valid S1 entry so a stalled result never changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
      r_s2_err  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= w_result;
        r_s2_err  <= w_err;
      end
    end
  end

`ifdef SHIFT_PIPELINE_ZERO_FLAG_EN
  logic r_s2_zero;

  always_ff @(posedge clk) begin
    if (rst)                        r_s2_zero <= 1'b0;
    else if (w_s2_load && r_s1_vld) r_s2_zero <= (w_result == '0);
  end

  assign o_zero = r_s2_zero;
`endif

  assign o_valid = r_s2_vld;
  assign o_data  = r_s2_data;
  assign o_err   = r_s2_err;
endmodule

// File: tb/tb_shift_pipeline.sv
// Directed-vector and scoreboard bench for shift_pipeline (N=32).
module tb_shift_pipeline;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [N-1:0]  i_data;
  logic [4:0]    i_shamt;
  logic [1:0]    i_op;
  logic          o_valid;
  logic          o_ready;
  logic [N-1:0]  o_data;
  logic          o_err;
`ifdef SHIFT_PIPELINE_ZERO_FLAG_EN
  logic          o_zero;
`endif

  shift_pipeline #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_shamt(i_shamt), .i_op(i_op),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
`ifdef SHIFT_PIPELINE_ZERO_FLAG_EN
    .o_zero(o_zero),
`endif
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [31:0]  data;
    logic [4:0]   shamt;
    logic [31:0]  exp_data;
    logic         exp_err;
    logic         exp_zero;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [33:0] sb_q[$];   // {zero, err, data}
  int sb_push = 0;
  int sb_pops = 0;

  // Values seen at the last negedge (cycle just completed) and the one before it.
  logic        s_ivld, s_irdy, s_ovld, s_ordy, s_oerr, s_ozero;
  logic [31:0] s_odata;
  logic        p_ovld = 1'b0, p_ordy = 1'b0, p_oerr = 1'b0, p_ozero = 1'b0;
  logic [31:0] p_odata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-by-bit reference, independent of shift operators.
  function automatic logic [33:0] model(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op);
    logic [31:0] r;
    int s;
    s = int'(sh);
    r = d;
    for (int i = 0; i < 32; i++) begin
      case (op)
        2'b00:   r[i] = (i >= s) ? d[i - s] : 1'b0;
        2'b01:   r[i] = (i + s < 32) ? d[i + s] : 1'b0;
        2'b10:   r[i] = (i + s < 32) ? d[i + s] : d[31];
        default: r[i] = d[i];
      endcase
    end
    return {(r == 32'h0), (op == 2'b11), r};
  endfunction

  task automatic monitor();
    logic [33:0] e;
    s_ivld = i_valid; s_irdy = i_ready; s_ovld = o_valid; s_ordy = o_ready;
    s_odata = o_data; s_oerr = o_err;
`ifdef SHIFT_PIPELINE_ZERO_FLAG_EN
    s_ozero = o_zero;
`else
    s_ozero = (o_data == 32'h0);
`endif
    if (rst) begin
      sb_q.delete();
      chk("irdy_in_reset", {63'h0, i_ready}, 64'h0);
    end else begin
      if (p_ovld && !p_ordy) begin
        chk("stall_stable", {s_ovld, s_oerr, s_ozero, s_odata}, {1'b1, p_oerr, p_ozero, p_odata});
      end
      if (o_valid && o_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", {32'h0, s_odata}, 64'hDEAD_0000_0000_0000);
        end else begin
          e = sb_q.pop_front();
          sb_pops++;
          chk("sb_data_err_zero", {30'h0, s_ozero, s_oerr, s_odata}, {30'h0, e[33], e[32], e[31:0]});
        end
      end
      if (i_valid && i_ready) begin
        sb_q.push_back(model(i_data, i_shamt, i_op));
        sb_push++;
      end
    end
    p_ovld = rst ? 1'b0 : s_ovld; p_ordy = s_ordy; p_odata = s_odata; p_oerr = s_oerr; p_ozero = s_ozero;
  endtask

  // One cycle: inputs set by the caller are sampled at negedge, then applied at the posedge.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    i_valid = 1'b1; i_op = v.op; i_data = v.data; i_shamt = v.shamt; o_ready = 1'b1;
    cyc();
    chk({nm, "_accept"}, {63'h0, s_irdy}, 64'h1);
    i_valid = 1'b0;
    cyc();
    chk({nm, "_lat1"}, {63'h0, s_ovld}, 64'h0);
    cyc();
    chk({nm, "_lat2"}, {63'h0, s_ovld}, 64'h1);
    chk({nm, "_data"}, {32'h0, s_odata}, {32'h0, v.exp_data});
    chk({nm, "_err"}, {63'h0, s_oerr}, {63'h0, v.exp_err});
`ifdef SHIFT_PIPELINE_ZERO_FLAG_EN
    chk({nm, "_zero"}, {63'h0, s_ozero}, {63'h0, v.exp_zero});
`endif
  endtask

  initial begin
    vec_t vecs[12];
    int base, cycles;
    vecs[0]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 32'h1234_ABCD, 5'd5,  32'h1234_ABCD, 1'b1, 1'b0};
    vecs[2]  = '{2'b01, 32'h0000_000F, 5'd4,  32'h0000_0000, 1'b0, 1'b1};
    vecs[3]  = '{2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0, 1'b1};
    vecs[6]  = '{2'b00, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 32'h1234_5678, 5'd8,  32'h3456_7800, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b1, 1'b0};

    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_shamt = '0; i_op = '0; o_ready = 1'b0;
    #1;
    repeat (3) cyc();
    chk("rst_ovalid", {63'h0, s_ovld}, 64'h0);
    chk("rst_odata_err", {31'h0, s_oerr, s_odata}, 64'h0);
    rst = 1'b0;
    cyc();
    chk("irdy_after_rst", {63'h0, s_irdy}, 64'h1);

    foreach (vecs[i]) single(vecs[i], i);

    // Back-to-back SLL 1<<k: 32 results in 34 cycles means one per cycle.
    base = sb_pops;
    o_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      i_valid = 1'b1; i_op = 2'b00; i_data = 32'h1; i_shamt = 5'(k);
      cyc();
      chk($sformatf("b2b_irdy%0d", k), {63'h0, s_irdy}, 64'h1);
    end
    i_valid = 1'b0;
    repeat (2) cyc();
    chk("b2b_count", 64'(sb_pops - base), 64'd32);

    // Backpressure: two accepts fill the pipe, third waits until o_ready rises.
    o_ready = 1'b0;
    i_valid = 1'b1; i_op = 2'b00; i_data = 32'h0000_0003; i_shamt = 5'd1;
    cyc();
    chk("bp_acc0", {63'h0, s_irdy}, 64'h1);
    i_op = 2'b01; i_data = 32'h0000_0F00; i_shamt = 5'd8;
    cyc();
    chk("bp_acc1", {63'h0, s_irdy}, 64'h1);
    i_op = 2'b10; i_data = 32'h8000_0010; i_shamt = 5'd4;
    cyc();
    chk("bp_full_irdy", {63'h0, s_irdy}, 64'h0);
    cyc();
    chk("bp_full_irdy2", {63'h0, s_irdy}, 64'h0);
    chk("bp_hold_data", {31'h0, s_ovld, s_odata}, {31'h0, 1'b1, 32'h0000_0006});
    base = sb_pops;
    o_ready = 1'b1;
    cyc();
    chk("bp_triple_move", {62'h0, s_irdy, s_ovld}, 64'h3);
    i_valid = 1'b0;
    repeat (3) cyc();
    chk("bp_drained", 64'(sb_pops - base), 64'd3);
    chk("bp_q_empty", 64'(sb_q.size()), 64'd0);

    // Reset with both stages full discards everything.
    o_ready = 1'b0; i_valid = 1'b1; i_op = 2'b00; i_data = 32'h55; i_shamt = 5'd2;
    repeat (2) cyc();
    i_valid = 1'b0;
    cyc();
    chk("pre_rst_full", {62'h0, s_ovld, s_irdy}, 64'h2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_ovalid", {63'h0, s_ovld}, 64'h0);
    chk("post_rst_irdy", {63'h0, s_irdy}, 64'h1);
    o_ready = 1'b1;
    base = sb_pops;
    repeat (3) cyc();
    chk("no_stale", {62'h0, s_ovld, 1'b0} | 64'(sb_pops - base), 64'h0);
    single(vecs[2], 2);

    // Random traffic against the reference model.
    base = sb_push;
    cycles = 0;
    while (sb_push - base < 10000 && cycles < 60000) begin
      i_valid = 1'($urandom_range(0, 1));
      o_ready = 1'($urandom_range(0, 1));
      i_op = 2'($urandom_range(0, 3));
      i_data = $urandom();
      i_shamt = 5'($urandom_range(0, 31));
      cyc();
      cycles++;
    end
    chk("rand_budget", {63'h0, (cycles >= 60000)}, 64'h0);
    i_valid = 1'b0; o_ready = 1'b1;
    repeat (4) cyc();
    chk("rand_q_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
